// File: rtl/traffic_signal_monitor.sv
// traffic_signal_monitor: checks lamp codes against signalling rules, latches the first fault and requests all-red
module traffic_signal_monitor #(
   parameter int MIN_Y    = 3,
   parameter int MIN_AR   = 1,
   parameter int MAX_WAIT = 32,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    hi_way,
   input  logic [1:0]    cnt_way,
   input  logic          x,
   input  logic          clr,
   output logic          fault,
   output logic [2:0]    fault_code,
   output logic          force_red,
   output logic [CW-1:0] viol_cnt
);
   localparam logic [1:0] RED = 2'd0, YEL = 2'd1, GRN = 2'd2, BAD = 2'd3;
   localparam logic [CW-1:0] MY = CW'(MIN_Y), MA = CW'(MIN_AR), MW1 = CW'(MAX_WAIT - 1);

   logic [1:0]    prev_h, prev_c;
   logic [CW-1:0] ydw_h, ydw_c, ar_cnt, wait_cnt;
   logic          bad, conf, ill, short_y, early_g, wait_hit, viol;
   logic [2:0]    code;

   function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   function automatic logic illegal(input logic [1:0] p, input logic [1:0] c);
      return (p == GRN && c == RED) || (p == RED && c == YEL) || (p == YEL && c == GRN);
   endfunction

   always_comb begin
      bad      = (hi_way == BAD) || (cnt_way == BAD);
      conf     = (hi_way != RED) && (cnt_way != RED);
      ill      = illegal(prev_h, hi_way) || illegal(prev_c, cnt_way);
      short_y  = (prev_h == YEL && hi_way == RED && ydw_h < MY) ||
                 (prev_c == YEL && cnt_way == RED && ydw_c < MY);
      early_g  = ((prev_h == RED && hi_way == GRN) || (prev_c == RED && cnt_way == GRN)) && (ar_cnt < MA);
      // flag only on the transition into MAX_WAIT so one wait episode yields one violation
      wait_hit = x && (cnt_way == RED) && (wait_cnt == MW1);
      code     = bad ? 3'd1 : conf ? 3'd2 : ill ? 3'd3 : short_y ? 3'd4 :
                 early_g ? 3'd5 : wait_hit ? 3'd6 : 3'd0;
      viol     = (code != 3'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_h     <= RED;
         prev_c     <= RED;
         ydw_h      <= '0;
         ydw_c      <= '0;
         ar_cnt     <= MA;
         wait_cnt   <= '0;
         viol_cnt   <= '0;
         fault      <= 1'b0;
         fault_code <= 3'd0;
      end else begin
         if (!bad) begin
            prev_h <= hi_way;
            prev_c <= cnt_way;
            ydw_h  <= (hi_way == YEL) ? inc(ydw_h) : '0;
            ydw_c  <= (cnt_way == YEL) ? inc(ydw_c) : '0;
         end
         ar_cnt   <= (hi_way == RED && cnt_way == RED) ? inc(ar_cnt) : '0;
         wait_cnt <= (x && cnt_way == RED) ? inc(wait_cnt) : '0;
         if (viol) viol_cnt <= inc(viol_cnt);
         if (viol && (!fault || clr)) begin
            fault      <= 1'b1;
            fault_code <= code;
         end else if (clr) begin
            fault      <= 1'b0;
            fault_code <= 3'd0;
         end
      end
   end

   assign force_red = fault;
endmodule

// File: doc/traffic_signal_monitor.md
# traffic_signal_monitor

Conflict monitor sitting on the output side of the traffic light controller. It samples the highway and country-road lamp codes every clock, checks them against the signalling rules, and tracks how long a car waiting on the country road has been held at red. On the first violation it latches a fault code and asserts a force-all-red request to the lamp drivers. It is the reader of the controller's lamp interface, in the same way the car sensor is that interface's input.

## Interface

- MIN_Y, 3: minimum consecutive YELLOW samples required before RED.
- MIN_AR, 1: minimum consecutive all-RED samples required before either road turns GREEN.
- MAX_WAIT, 32: maximum consecutive samples with x=1 and cnt_way=RED before starvation is flagged.
- CW, 8: width of the internal dwell/wait counters and of viol_cnt.

- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low; asserted (0) forces all state to reset values immediately.
- hi_way, input, 2: highway lamp code; RED=2'd0, YELLOW=2'd1, GREEN=2'd2, 2'd3 illegal.
- cnt_way, input, 2: country-road lamp code, same encoding.
- x, input, 1: country-road car sensor, the same signal the controller sees.
- clr, input, 1: synchronous fault clear.
- fault, output, 1: sticky fault flag.
- fault_code, output, 3: code of the first latched violation; 0 means none.
- force_red, output, 1: request to the lamp drivers to show RED on both roads; equals fault.
- viol_cnt, output, CW: saturating count of violating samples since reset.

## Operation

- Per road, keep prev (the previous sample) and ydwell (consecutive YELLOW samples, saturating).
- Keep ar_cnt (consecutive samples with both roads RED, saturating) and wait_cnt (consecutive samples with x=1 and cnt_way=RED, saturating).
- Violation codes are checked on every sample. When several hit in the same sample, the lowest code wins.
  - 1: either input equals 2'd3.
  - 2: both roads are non-RED in the same sample (conflict).
  - 3: illegal transition on either road: GREEN→RED, RED→YELLOW, or YELLOW→GREEN. Holding a state, RED→GREEN, GREEN→YELLOW and YELLOW→RED are legal.
  - 4: YELLOW→RED while that road's ydwell < MIN_Y.
  - 5: RED→GREEN on either road while ar_cnt < MIN_AR.
  - 6: wait_cnt reaches MAX_WAIT (flagged once per wait episode, on the sample where it first equals MAX_WAIT).
- Any violating sample increments viol_cnt, which saturates at 2^CW-1.
- If fault=0, a violating sample sets fault=1 and fault_code to the winning code.
- If fault=1, later violations leave fault_code unchanged but still count in viol_cnt.
- clr=1 clears fault and fault_code and leaves viol_cnt unchanged. If clr=1 coincides with a violating sample, the new violation is latched and clr loses.
- wait_cnt resets to 0 whenever x=0 or cnt_way≠RED.
- A code-1 sample does not update prev or ydwell; only legal codes are stored.

## Timing

- Reset values: fault=0, fault_code=0, force_red=0, viol_cnt=0.
- Reset values of internal state: prev=RED for both roads, ydwell=0, wait_cnt=0, and ar_cnt=MIN_AR so that the first GREEN after reset is legal.
- Sample on posedge N; outputs reflect that sample after edge N. Latency is one cycle from input to fault.
- All outputs are registered, with no combinational path from the inputs.
- Deasserting reset mid-sequence restarts all checks from the reset state, with no stale history.

## Test plan

- Reset, then hi_way GREEN ×5, YELLOW ×3, RED with cnt_way RED ×1, then cnt_way GREEN → fault stays 0 and viol_cnt=0.
- hi_way=GREEN and cnt_way=YELLOW in the same sample → fault=1, fault_code=2 and force_red=1 one cycle later; viol_cnt=1.
- hi_way YELLOW ×2 then RED with MIN_Y=3 → fault_code=4. Then clr=1 → fault=0, fault_code=0, viol_cnt still 1.
- hi_way YELLOW→RED and cnt_way RED→GREEN on the same edge → ar_cnt=0, so fault_code=5.
- x=1 with cnt_way held RED for 32 samples → fault_code=6 exactly on the 32nd sample. Drop x to 0, then hold 31 more samples → no second violation.
- hi_way=2'd3 and conflict together → fault_code=1, the lowest code. Assert reset mid-hold → all outputs return to 0 immediately (asynchronous).
